// File: rtl/hamming_tx.sv
// Hamming(7,4) encoder feeding a UART-style serial transmitter (start, 7 code bits MSB first, stop).
// Optional single-bit error injection on the latched codeword.
module hamming_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_i,
    input  logic       data_valid_i,
    input  logic [2:0] err_pos_i,
    output logic       data_ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic [6:0] code_out_o
);

    localparam int unsigned CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CODE_W-1:0]   shift_q, shift_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic [CODE_W-1:0]   clean_code_c;
    logic [CODE_W-1:0]   flip_mask_c;
    logic [CODE_W-1:0]   inj_code_c;
    logic                bit_end_c;

    // Parity is always computed on the clean nibble; injection is applied afterwards.
    always_comb begin
        clean_code_c = {data_i,
                        data_i[3] ^ data_i[2] ^ data_i[1],
                        data_i[3] ^ data_i[2] ^ data_i[0],
                        data_i[3] ^ data_i[1] ^ data_i[0]};
        flip_mask_c  = '0;
        if (err_pos_i != 3'd0) begin
            flip_mask_c = CODE_W'(1) << (err_pos_i - 3'd1);
        end
        inj_code_c   = clean_code_c ^ flip_mask_c;
    end

    assign bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        code_d  = code_q;
        tx_d    = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b1;

        case (state_q)
            IDLE: begin
                if (data_valid_i) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    shift_d = inj_code_c;
                    code_d  = inj_code_c;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(CODE_W - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[CODE_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so the registered versions line up with it.
        case (state_d)
            IDLE:    begin tx_d = 1'b1;            ready_d = 1'b1; busy_d = 1'b0; end
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[CODE_W-1];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            code_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            code_q  <= code_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign tx_o         = tx_q;
    assign data_ready_o = ready_q;
    assign busy_o       = busy_q;
    assign code_out_o   = code_q;

endmodule
